// File: rtl/botao_para_pulso.sv
// Push-button conditioner: synchronises the raw active-low button, debounces it with a
// four-state FSM and emits a single one-clock action pulse per accepted press.
module botao_para_pulso #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       botao_n,
   output logic       action_pulso,
   output logic       botao_estavel,
   output logic [1:0] estado
);

   typedef enum logic [1:0] {
      Solto         = 2'b00,
      ConfirmaPress = 2'b01,
      Pressionado   = 2'b10,
      ConfirmaSolta = 2'b11
   } estado_t;

   // Last count value of a confirmation window; the counter never goes past it.
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             p;
   estado_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulso_q, pulso_d;
   logic             estavel_q, estavel_d;

   // Two-flop synchroniser; resets to the released (high) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= botao_n;
         sync2_q <= sync1_q;
      end
   end

   assign p = ~sync2_q;

   // Next-state logic: every level change must hold for DEBOUNCE_CYCLES samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulso_d = 1'b0;
      case (state_q)
         Solto: begin
            if (p) begin
               state_d = ConfirmaPress;
               cnt_d   = '0;
            end
         end
         ConfirmaPress: begin
            if (!p) begin
               state_d = Solto;
            end else if (cnt_q == CntMax) begin
               state_d = Pressionado;
               pulso_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         Pressionado: begin
            if (!p) begin
               state_d = ConfirmaSolta;
               cnt_d   = '0;
            end
         end
         ConfirmaSolta: begin
            if (p) begin
               state_d = Pressionado;
            end else if (cnt_q == CntMax) begin
               state_d = Solto;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = Solto;
            cnt_d   = '0;
         end
      endcase
      // Stable level follows the state being registered alongside it.
      estavel_d = (state_d == Pressionado) || (state_d == ConfirmaSolta);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= Solto;
         cnt_q     <= '0;
         pulso_q   <= 1'b0;
         estavel_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pulso_q   <= pulso_d;
         estavel_q <= estavel_d;
      end
   end

   assign action_pulso  = pulso_q;
   assign botao_estavel = estavel_q;
   assign estado        = state_q;

endmodule

// File: tb/tb_botao_para_pulso.sv
// Directed bench for botao_para_pulso with DEBOUNCE_CYCLES=4: expected pulse edges are queued
// when a press is driven and matched by a monitor whenever action_pulso is seen high.
module tb_botao_para_pulso;

   localparam int unsigned D = 4;
   // A press driven just after edge e is first sampled at e+1 and pulses at e+1+D+2.
   localparam int LAT = D + 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       botao_n;
   logic       action_pulso;
   logic       botao_estavel;
   logic [1:0] estado;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int sb[$];

   botao_para_pulso #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .botao_n      (botao_n),
      .action_pulso (action_pulso),
      .botao_estavel(botao_estavel),
      .estado       (estado)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [1:0] e_est, input logic e_stab,
                             input logic e_pulse);
      check({tag, ".estado"}, 32'(estado), 32'(e_est));
      check({tag, ".estavel"}, 32'(botao_estavel), 32'(e_stab));
      check({tag, ".pulso"}, 32'(action_pulso), 32'(e_pulse));
   endtask

   // Pulse monitor: every pulse must match the queued edge; an overdue entry is a missed pulse.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0] < cyc) begin
         checks++;
         errors++;
         $error("FAIL missed_pulse: observed none expected pulse at edge %0d", sb[0]);
         void'(sb.pop_front());
      end
      if (action_pulso === 1'b1) begin
         checks++;
         assert (sb.size() > 0 && sb[0] == cyc)
         else begin
            errors++;
            $error("FAIL pulse_edge: observed pulse at edge %0d expected %0d", cyc,
                   (sb.size() > 0) ? sb[0] : -1);
         end
         if (sb.size() > 0) void'(sb.pop_front());
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, checked without any clock edge.
      rst_n   = 1'b0;
      botao_n = 1'b1;
      #1;
      check_outs("reset", 2'b00, 1'b0, 1'b0);
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // Clean press held 30 cycles, then clean release.
      botao_n = 1'b0;
      sb.push_back(cyc + LAT);
      tick(2);
      check_outs("press_sync", 2'b00, 1'b0, 1'b0);
      tick(1);
      check_outs("press_confirm", 2'b01, 1'b0, 1'b0);
      tick(3);
      check_outs("press_confirm_end", 2'b01, 1'b0, 1'b0);
      tick(1);
      check_outs("press_accept", 2'b10, 1'b1, 1'b1);
      tick(1);
      check_outs("press_after", 2'b10, 1'b1, 1'b0);
      tick(22);
      botao_n = 1'b1;
      tick(3);
      check_outs("rel_confirm", 2'b11, 1'b1, 1'b0);
      tick(3);
      check_outs("rel_confirm_end", 2'b11, 1'b1, 1'b0);
      tick(1);
      check_outs("rel_accept", 2'b00, 1'b0, 1'b0);
      tick(5);

      // Bounce: low 3, high 1, low 3, high -> never accepted.
      botao_n = 1'b0;
      tick(3);
      botao_n = 1'b1;
      tick(1);
      botao_n = 1'b0;
      tick(3);
      check_outs("bounce_mid", 2'b01, 1'b0, 1'b0);
      botao_n = 1'b1;
      tick(10);
      check_outs("bounce_end", 2'b00, 1'b0, 1'b0);

      // Long hold with a short release bounce, then clean release.
      botao_n = 1'b0;
      sb.push_back(cyc + LAT);
      tick(20);
      check_outs("hold", 2'b10, 1'b1, 1'b0);
      botao_n = 1'b1;
      tick(2);
      botao_n = 1'b0;
      tick(1);
      check_outs("relbounce_confirm", 2'b11, 1'b1, 1'b0);
      tick(2);
      check_outs("relbounce_back", 2'b10, 1'b1, 1'b0);
      tick(75);
      botao_n = 1'b1;
      tick(6);
      check_outs("long_rel_confirm", 2'b11, 1'b1, 1'b0);
      tick(1);
      check_outs("long_rel_accept", 2'b00, 1'b0, 1'b0);
      tick(5);

      // Reset in the middle of a press confirmation (cnt=2), button kept low.
      botao_n = 1'b0;
      sb.push_back(cyc + LAT);
      tick(5);
      check_outs("mid_confirm", 2'b01, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_outs("mid_reset", 2'b00, 1'b0, 1'b0);
      sb.delete();
      tick(2);
      rst_n = 1'b1;
      sb.push_back(cyc + LAT);
      tick(LAT);
      check_outs("post_reset_press", 2'b10, 1'b1, 1'b1);
      botao_n = 1'b1;
      tick(10);
      check_outs("post_reset_rel", 2'b00, 1'b0, 1'b0);

      // Reset during the pulse cycle kills the pulse at once.
      botao_n = 1'b0;
      sb.push_back(cyc + LAT);
      tick(LAT);
      check("pulse_before_reset", 32'(action_pulso), 32'd1);
      rst_n = 1'b0;
      #1;
      check_outs("pulse_reset", 2'b00, 1'b0, 1'b0);
      sb.delete();
      botao_n = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(10);
      check_outs("pulse_reset_idle", 2'b00, 1'b0, 1'b0);

      // Back-to-back presses: 10 low, 10 high, 10 low.
      botao_n = 1'b0;
      sb.push_back(cyc + LAT);
      tick(10);
      botao_n = 1'b1;
      tick(10);
      check_outs("b2b_gap", 2'b00, 1'b0, 1'b0);
      botao_n = 1'b0;
      sb.push_back(cyc + LAT);
      tick(10);
      botao_n = 1'b1;
      tick(15);
      check_outs("b2b_end", 2'b00, 1'b0, 1'b0);

      check("queue_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/botao_para_pulso.md
BOTAO_PARA_PULSO -- requirements
Module: botao_para_pulso

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, SHALL set the number of consecutive stable synchronized samples needed to accept a level change (1 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 16, SHALL set the debounce counter width; 2**CNT_W >= DEBOUNCE_CYCLES and DEBOUNCE_CYCLES >= 2 SHALL hold.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 botao_n  input  1  raw push-button, active-low (0 = pressed), asynchronous to clk, may bounce.
REQ-006 action_pulso  output  1  one-clk-wide, active-high pulse per accepted press; this is the sole action input of the RPN sequencer.
REQ-007 botao_estavel  output  1  debounced level, 1 = pressed.
REQ-008 estado  output  2  current FSM state code, for debug LEDs.

Function
REQ-009 botao_n SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use; p = ~sync2 is the synchronized "pressed" signal.
REQ-010 FSM states/codes: SOLTO=00, CONFIRMA_PRESS=01, PRESSIONADO=10, CONFIRMA_SOLTA=11; estado SHALL equal the state register.
REQ-011 SOLTO: p=1 -> CONFIRMA_PRESS with cnt<=0; else stay.
REQ-012 CONFIRMA_PRESS: p=0 -> SOLTO, no pulse; p=1 and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1; p=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSIONADO.
REQ-013 PRESSIONADO: p=0 -> CONFIRMA_SOLTA with cnt<=0; else stay (no further pulses, regardless of hold time).
REQ-014 CONFIRMA_SOLTA: p=1 -> PRESSIONADO, no pulse; p=0 and cnt==DEBOUNCE_CYCLES-1 -> SOLTO; else cnt<=cnt+1.
REQ-015 action_pulso SHALL be a registered output, 1 for exactly the one cycle following the CONFIRMA_PRESS->PRESSIONADO edge, 0 at all other times.
REQ-016 Latency: for a clean press first sampled low at edge k, action_pulso SHALL rise at edge k+DEBOUNCE_CYCLES+2 and fall at the next edge.
REQ-017 botao_estavel SHALL be 1 in PRESSIONADO and CONFIRMA_SOLTA, 0 in SOLTO and CONFIRMA_PRESS (registered with state).
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES samples SHALL cause no pulse and no botao_estavel change.
REQ-019 Two accepted presses SHALL be separated by a full accepted release; minimum spacing between pulses is 2*DEBOUNCE_CYCLES+2 cycles.
REQ-020 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL not wrap.

Reset
REQ-021 rst_n=0 SHALL immediately, without clk: sync1=sync2=1, state=SOLTO, cnt=0, action_pulso=0, botao_estavel=0.
REQ-022 Reset asserted mid-confirmation or during a pulse cycle SHALL force action_pulso=0 at once and discard the pending press.
REQ-023 A button held low through reset release SHALL be treated as a new press: one pulse after DEBOUNCE_CYCLES+2 edges post-release.

Verification (DEBOUNCE_CYCLES=4, CNT_W=3)
REQ-024 Clean press: botao_n 1->0 sampled at edge 10, held 30 cycles -> action_pulso=1 only during cycle after edge 16, botao_estavel=1 from edge 16, estado 00->01->10.
REQ-025 Bounce: botao_n low 3 cycles, high 1, low 3, high -> no pulse, estado returns 00, botao_estavel stays 0.
REQ-026 Long hold then release: hold 100 cycles, release clean -> exactly one pulse; botao_estavel returns 0 at release edge+6; estado 10->11->00.
REQ-027 Release bounce: in PRESSIONADO, botao_n high 2 cycles then low -> estado 11->10, no second pulse, botao_estavel stays 1.
REQ-028 Reset mid-operation: rst_n=0 at confirm cnt=2 -> outputs 0 and estado 00 at once; release with botao_n still low -> one pulse 6 edges later.
REQ-029 Back-to-back: two clean presses each 10 cycles with 10-cycle gap -> exactly two pulses, each 1 cycle wide.
